// File: rtl/spi_sim_pkg.sv
// Shared constants, state type and clamp helpers for the simulated SPI bus generator.
package spi_sim_pkg;

    localparam logic [19:0] ADDR_CTRL  = 20'h00080;
    localparam logic [19:0] ADDR_HALF  = 20'h00084;
    localparam logic [19:0] ADDR_NBITS = 20'h00088;
    localparam logic [19:0] ADDR_MOSI  = 20'h0008C;
    localparam logic [19:0] ADDR_MISO  = 20'h00090;
    localparam logic [19:0] ADDR_GAP   = 20'h00094;

    localparam logic [15:0] RST_HALF  = 16'd5;
    localparam logic [5:0]  RST_NBITS = 6'd16;
    localparam logic [31:0] RST_MOSI  = 32'h0000_33AA;
    localparam logic [31:0] RST_MISO  = 32'h0000_3303;
    localparam logic [15:0] RST_GAP   = 16'd20;

    localparam logic [15:0] MIN_HALF = 16'd2;
    localparam logic [15:0] MIN_GAP  = 16'd4;

    typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, HOLD, GAP} spiState_t;

    function automatic logic [15:0] clampHalf(input logic [15:0] v);
        return (v < MIN_HALF) ? MIN_HALF : v;
    endfunction

    function automatic logic [15:0] clampGap(input logic [15:0] v);
        return (v < MIN_GAP) ? MIN_GAP : v;
    endfunction

    function automatic logic [5:0] clampBits(input logic [5:0] v);
        return ((v == 6'd0) || (v > 6'd32)) ? 6'd32 : v;
    endfunction

endpackage

// File: rtl/spi_master_sim_if.sv
// System bus write port of the simulated SPI bus generator.
interface spi_master_sim_if;
    logic [31:0] sys_addr;
    logic [31:0] sys_wdata;
    logic        sys_wen;

    modport master (output sys_addr, output sys_wdata, output sys_wen);
    modport slave  (input  sys_addr, input  sys_wdata, input  sys_wen);
endinterface

// File: rtl/spi_sim_phase_cnt.sv
// Loadable 16-bit down-counter; tc is high while the count sits at zero.
module spi_sim_phase_cnt (
    input  logic        clk,
    input  logic        rstn,
    input  logic        load,
    input  logic [15:0] loadVal,
    output logic        tc
);
    logic [15:0] count;

    // load wins; otherwise count down and park at zero
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count <= '0;
        end else if (load) begin
            count <= loadVal;
        end else if (count != '0) begin
            count <= count - 16'd1;
        end
    end

    assign tc = (count == '0);
endmodule

// File: rtl/spi_master_sim.sv
// SPI mode-0 telegram generator driving cs/sclk/mosi and a simulated slave miso.
module spi_master_sim
    import spi_sim_pkg::*;
(
    input  logic            clk,
    input  logic            rstn,
    spi_master_sim_if.slave bus,
    output logic            cs,
    output logic            sclk,
    output logic            mosi,
    output logic            miso,
    output logic            busy,
    output logic            done
);
    logic        ctrlCont;
    logic [15:0] halfReg;
    logic [5:0]  nReg;
    logic [31:0] mosiReg;
    logic [31:0] misoReg;
    logic [15:0] gapReg;

    spiState_t   state;
    logic [15:0] shHalf;
    logic [15:0] shGap;
    logic [5:0]  bitCnt;
    logic        holdSecond;
    logic [31:0] mosiSh;
    logic [31:0] misoSh;

    logic        startWr;
    logic        doStart;
    logic        tc;
    logic        cntLoad;
    logic [15:0] cntVal;
    logic [15:0] startHalf;
    logic [5:0]  startN;
    logic [31:0] mosiStart;
    logic [31:0] misoStart;
    logic        unusedAddr;

    assign unusedAddr = ^bus.sys_addr[31:20];
    assign startWr    = bus.sys_wen && (bus.sys_addr[19:0] == ADDR_CTRL) && bus.sys_wdata[1];
    assign startHalf  = clampHalf(halfReg);
    assign startN     = clampBits(nReg);
    // Left-align the words so bit N-1 sits at bit 31 and shifts out first.
    assign mosiStart  = mosiReg << (6'd32 - startN);
    assign misoStart  = misoReg << (6'd32 - startN);

    // register file; start is a strobe and is never stored
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ctrlCont <= 1'b0;
            halfReg  <= RST_HALF;
            nReg     <= RST_NBITS;
            mosiReg  <= RST_MOSI;
            misoReg  <= RST_MISO;
            gapReg   <= RST_GAP;
        end else if (bus.sys_wen) begin
            case (bus.sys_addr[19:0])
                ADDR_CTRL:  ctrlCont <= bus.sys_wdata[0];
                ADDR_HALF:  halfReg  <= bus.sys_wdata[15:0];
                ADDR_NBITS: nReg     <= bus.sys_wdata[5:0];
                ADDR_MOSI:  mosiReg  <= bus.sys_wdata;
                ADDR_MISO:  misoReg  <= bus.sys_wdata;
                ADDR_GAP:   gapReg   <= bus.sys_wdata[15:0];
                default: ;
            endcase
        end
    end

    // message start decision and phase-counter reload for the next phase
    always_comb begin
        doStart = ((state == IDLE) && (startWr || ctrlCont)) ||
                  ((state == GAP) && tc && ctrlCont);
        cntLoad = doStart || ((state != IDLE) && tc);
        cntVal  = shHalf - 16'd1;
        if (doStart) begin
            cntVal = startHalf - 16'd1;
        end else if ((state == HOLD) && holdSecond) begin
            cntVal = shGap - 16'd1;
        end
    end

    spi_sim_phase_cnt phaseCnt (
        .clk     (clk),
        .rstn    (rstn),
        .load    (cntLoad),
        .loadVal (cntVal),
        .tc      (tc)
    );

    // telegram FSM with registered pin outputs
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            cs         <= 1'b1;
            sclk       <= 1'b0;
            mosi       <= 1'b0;
            miso       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            shHalf     <= MIN_HALF;
            shGap      <= MIN_GAP;
            bitCnt     <= '0;
            holdSecond <= 1'b0;
            mosiSh     <= '0;
            misoSh     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: ;
                SETUP, LOW: begin
                    if (tc) begin
                        state <= HIGH;
                        sclk  <= 1'b1;
                    end
                end
                HIGH: begin
                    if (tc) begin
                        sclk   <= 1'b0;
                        bitCnt <= bitCnt - 6'd1;
                        if (bitCnt == 6'd1) begin
                            state      <= HOLD;
                            holdSecond <= 1'b0;
                        end else begin
                            state  <= LOW;
                            mosi   <= mosiSh[30];
                            miso   <= misoSh[30];
                            mosiSh <= {mosiSh[30:0], 1'b0};
                            misoSh <= {misoSh[30:0], 1'b0};
                        end
                    end
                end
                // Trailing sclk-low time spans two half periods so cs stays low half*(2N+2).
                HOLD: begin
                    if (tc) begin
                        if (!holdSecond) begin
                            holdSecond <= 1'b1;
                        end else begin
                            state <= GAP;
                            cs    <= 1'b1;
                            mosi  <= 1'b0;
                            miso  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                GAP: begin
                    if (tc && !ctrlCont) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
            // A start (from IDLE or a continuous GAP exit) overrides the case above.
            if (doStart) begin
                state      <= SETUP;
                cs         <= 1'b0;
                sclk       <= 1'b0;
                busy       <= 1'b1;
                mosi       <= mosiStart[31];
                miso       <= misoStart[31];
                mosiSh     <= mosiStart;
                misoSh     <= misoStart;
                bitCnt     <= startN;
                shHalf     <= startHalf;
                shGap      <= clampGap(gapReg);
                holdSecond <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_spi_master_sim.sv
// Randomised self-checking bench for spi_master_sim against a telegram-level model.
module tb_spi_master_sim;

    logic clk = 1'b0;
    logic rstn = 1'b1;
    logic cs, sclk, mosi, miso, busy, done;

    spi_master_sim_if bus();

    spi_master_sim dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus),
        .cs   (cs),
        .sclk (sclk),
        .mosi (mosi),
        .miso (miso),
        .busy (busy),
        .done (done)
    );

    always #5 clk = ~clk;

    int nTests = 0;
    int nFail  = 0;

    typedef struct {
        int          csLow;
        int          edges;
        logic [63:0] mosiBits;
        logic [63:0] misoBits;
        int          firstEdge;
        int          minHigh;
        int          maxHigh;
        int          doneCnt;
        logic        doneAtRise;
        int          gapBefore;
        int          mode0Err;
    } msg_t;

    msg_t recs[$];
    int   csFalls = 0;

    // ---------------- reference model ----------------
    function automatic int effHalf(input int v);
        return (v < 2) ? 2 : v;
    endfunction

    function automatic int effN(input int v);
        return ((v == 0) || (v > 32)) ? 32 : v;
    endfunction

    function automatic int effGap(input int v);
        return (v < 4) ? 4 : v;
    endfunction

    // bits expected on the wire, oldest in the MSB of the low n bits
    function automatic logic [63:0] expBits(input logic [31:0] w, input int n);
        logic [63:0] mask;
        mask = (64'd1 << n) - 64'd1;
        return {32'd0, w} & mask;
    endfunction

    function automatic int expCsLow(input int h, input int n);
        return effHalf(h) * (2 * effN(n) + 2);
    endfunction

    // ---------------- bus monitor ----------------
    initial begin : monitor
        msg_t cur;
        logic pCs, pSclk, pMosi, pMiso, inMsg;
        int   highRun, csHighRun;
        pCs = 1'b1; pSclk = 1'b0; pMosi = 1'b0; pMiso = 1'b0; inMsg = 1'b0;
        highRun = 0; csHighRun = 0;
        cur = '{default: 0};
        forever begin
            @(negedge clk);
            if (!rstn) begin
                pCs = 1'b1; pSclk = 1'b0; pMosi = 1'b0; pMiso = 1'b0;
                inMsg = 1'b0; csHighRun = 0;
            end else begin
                if (pCs && !cs) begin
                    cur = '{default: 0};
                    cur.minHigh = 1 << 30;
                    cur.gapBefore = csHighRun;
                    inMsg = 1'b1;
                    csFalls++;
                end
                if (cs) csHighRun++; else csHighRun = 0;
                if (!cs && inMsg) begin
                    cur.csLow++;
                    if (sclk && !pSclk) begin
                        cur.edges++;
                        if (cur.edges == 1) cur.firstEdge = cur.csLow - 1;
                        cur.mosiBits = {cur.mosiBits[62:0], mosi};
                        cur.misoBits = {cur.misoBits[62:0], miso};
                    end
                    if (sclk) highRun = pSclk ? highRun + 1 : 1;
                    if (!sclk && pSclk) begin
                        if (highRun < cur.minHigh) cur.minHigh = highRun;
                        if (highRun > cur.maxHigh) cur.maxHigh = highRun;
                    end
                    if (sclk && ((mosi !== pMosi) || (miso !== pMiso))) cur.mode0Err++;
                end
                if (done && inMsg) cur.doneCnt++;
                if (!pCs && cs && inMsg) begin
                    cur.doneAtRise = done;
                    recs.push_back(cur);
                    inMsg = 1'b0;
                end
                pCs = cs; pSclk = sclk; pMosi = mosi; pMiso = miso;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic busWrite(input logic [19:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.sys_addr  = {12'h000, a};
        bus.sys_wdata = d;
        bus.sys_wen   = 1'b1;
        @(negedge clk);
        bus.sys_wen   = 1'b0;
        #1;
    endtask

    task automatic waitMsg(output msg_t r, output bit ok);
        int n;
        n = 0;
        while (recs.size() == 0 && n < 3000) begin
            @(negedge clk); #1;
            n++;
        end
        ok = (recs.size() != 0);
        if (ok) r = recs.pop_front();
        else    r = '{default: 0};
    endtask

    task automatic busyRun(output int n);
        n = 0;
        while (busy === 1'b1 && n < 1000) begin
            n++;
            @(negedge clk); #1;
        end
    endtask

    task automatic idleCycles(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        #2 rstn = 1'b0;
        #1;
        nTests++; if (cs !== 1'b1)   begin nFail++; $display("FAIL reset_cs got %b want 1", cs); end
        nTests++; if (sclk !== 1'b0) begin nFail++; $display("FAIL reset_sclk got %b want 0", sclk); end
        nTests++; if (mosi !== 1'b0) begin nFail++; $display("FAIL reset_mosi got %b want 0", mosi); end
        nTests++; if (miso !== 1'b0) begin nFail++; $display("FAIL reset_miso got %b want 0", miso); end
        nTests++; if (busy !== 1'b0) begin nFail++; $display("FAIL reset_busy got %b want 0", busy); end
        nTests++; if (done !== 1'b0) begin nFail++; $display("FAIL reset_done got %b want 0", done); end
        idleCycles(3);
        rstn = 1'b1;
        idleCycles(3);
    endtask

    task automatic test_default;
        msg_t r; bit ok; int g;
        busWrite(20'h80, 32'd2);
        nTests++; if (cs !== 1'b0)   begin nFail++; $display("FAIL default_latency_cs got %b want 0", cs); end
        nTests++; if (busy !== 1'b1) begin nFail++; $display("FAIL default_latency_busy got %b want 1", busy); end
        waitMsg(r, ok);
        nTests++; if (!ok) begin nFail++; $display("FAIL default_timeout got none want message"); end
        nTests++; if (r.csLow !== 170) begin nFail++; $display("FAIL default_csLow got %0d want 170", r.csLow); end
        nTests++; if (r.edges !== 16) begin nFail++; $display("FAIL default_edges got %0d want 16", r.edges); end
        nTests++; if (r.mosiBits !== expBits(32'h33AA, 16)) begin nFail++; $display("FAIL default_mosi got %h want %h", r.mosiBits, expBits(32'h33AA, 16)); end
        nTests++; if (r.misoBits !== expBits(32'h3303, 16)) begin nFail++; $display("FAIL default_miso got %h want %h", r.misoBits, expBits(32'h3303, 16)); end
        nTests++; if (r.firstEdge !== 5) begin nFail++; $display("FAIL default_firstEdge got %0d want 5", r.firstEdge); end
        nTests++; if (r.minHigh !== 5 || r.maxHigh !== 5) begin nFail++; $display("FAIL default_highWidth got %0d..%0d want 5", r.minHigh, r.maxHigh); end
        nTests++; if (r.doneCnt !== 1 || r.doneAtRise !== 1'b1) begin nFail++; $display("FAIL default_done got cnt=%0d atRise=%b want 1/1", r.doneCnt, r.doneAtRise); end
        nTests++; if (r.mode0Err !== 0) begin nFail++; $display("FAIL default_mode0 got %0d want 0", r.mode0Err); end
        busyRun(g);
        nTests++; if (g !== 20) begin nFail++; $display("FAIL default_gap_busy got %0d want 20", g); end
    endtask

    task automatic test_clamp;
        msg_t r; bit ok; logic [31:0] sw; int g;
        sw = $urandom;
        busWrite(20'h84, 32'd0);
        busWrite(20'h88, 32'd1);
        busWrite(20'h8C, 32'd1);
        busWrite(20'h90, sw);
        busWrite(20'h94, 32'd1);
        busWrite(20'h80, 32'd2);
        waitMsg(r, ok);
        nTests++; if (!ok) begin nFail++; $display("FAIL clamp_timeout got none want message"); end
        nTests++; if (r.csLow !== 8) begin nFail++; $display("FAIL clamp_csLow got %0d want 8", r.csLow); end
        nTests++; if (r.edges !== 1) begin nFail++; $display("FAIL clamp_edges got %0d want 1", r.edges); end
        nTests++; if (r.minHigh !== 2 || r.maxHigh !== 2) begin nFail++; $display("FAIL clamp_highWidth got %0d..%0d want 2", r.minHigh, r.maxHigh); end
        nTests++; if (r.mosiBits !== 64'd1) begin nFail++; $display("FAIL clamp_mosi got %h want 1", r.mosiBits); end
        nTests++; if (r.misoBits !== expBits(sw, 1)) begin nFail++; $display("FAIL clamp_miso got %h want %h", r.misoBits, expBits(sw, 1)); end
        busyRun(g);
        nTests++; if (g !== 4) begin nFail++; $display("FAIL clamp_gap_busy got %0d want 4", g); end
    endtask

    task automatic test_n32;
        msg_t r; bit ok; int h, g; logic [31:0] sw;
        h  = $urandom_range(2, 3);
        sw = $urandom;
        busWrite(20'h84, h);
        busWrite(20'h88, 32'd0);
        busWrite(20'h8C, 32'h8000_0001);
        busWrite(20'h90, sw);
        busWrite(20'h94, 32'd6);
        busWrite(20'h80, 32'd2);
        waitMsg(r, ok);
        nTests++; if (!ok) begin nFail++; $display("FAIL n32_timeout got none want message"); end
        nTests++; if (r.edges !== 32) begin nFail++; $display("FAIL n32_edges got %0d want 32", r.edges); end
        nTests++; if (r.mosiBits !== 64'h0000_0000_8000_0001) begin nFail++; $display("FAIL n32_mosi got %h want 80000001", r.mosiBits); end
        nTests++; if (r.misoBits !== expBits(sw, 32)) begin nFail++; $display("FAIL n32_miso got %h want %h", r.misoBits, expBits(sw, 32)); end
        nTests++; if (r.csLow !== h * 66) begin nFail++; $display("FAIL n32_csLow got %0d want %0d", r.csLow, h * 66); end
        busyRun(g);
        nTests++; if (g !== 6) begin nFail++; $display("FAIL n32_gap_busy got %0d want 6", g); end
    endtask

    task automatic test_random;
        msg_t r; bit ok; int h, n, gp, eh, en, g; logic [31:0] mw, sw;
        for (int it = 0; it < 6; it++) begin
            h  = $urandom_range(0, 5);
            n  = $urandom_range(0, 63);
            gp = $urandom_range(0, 10);
            mw = $urandom;
            sw = $urandom;
            eh = effHalf(h);
            en = effN(n);
            busWrite(20'h84, h);
            busWrite(20'h88, n);
            busWrite(20'h8C, mw);
            busWrite(20'h90, sw);
            busWrite(20'h94, gp);
            busWrite(20'h80, 32'd2);
            waitMsg(r, ok);
            nTests++; if (!ok) begin nFail++; $display("FAIL rand%0d_timeout got none want message", it); end
            nTests++; if (r.csLow !== expCsLow(h, n)) begin nFail++; $display("FAIL rand%0d_csLow got %0d want %0d", it, r.csLow, expCsLow(h, n)); end
            nTests++; if (r.edges !== en) begin nFail++; $display("FAIL rand%0d_edges got %0d want %0d", it, r.edges, en); end
            nTests++; if (r.mosiBits !== expBits(mw, en)) begin nFail++; $display("FAIL rand%0d_mosi got %h want %h", it, r.mosiBits, expBits(mw, en)); end
            nTests++; if (r.misoBits !== expBits(sw, en)) begin nFail++; $display("FAIL rand%0d_miso got %h want %h", it, r.misoBits, expBits(sw, en)); end
            nTests++; if (r.firstEdge !== eh) begin nFail++; $display("FAIL rand%0d_firstEdge got %0d want %0d", it, r.firstEdge, eh); end
            nTests++; if (r.minHigh !== eh || r.maxHigh !== eh) begin nFail++; $display("FAIL rand%0d_highWidth got %0d..%0d want %0d", it, r.minHigh, r.maxHigh, eh); end
            nTests++; if (r.doneCnt !== 1 || r.doneAtRise !== 1'b1) begin nFail++; $display("FAIL rand%0d_done got cnt=%0d atRise=%b want 1/1", it, r.doneCnt, r.doneAtRise); end
            nTests++; if (r.mode0Err !== 0) begin nFail++; $display("FAIL rand%0d_mode0 got %0d want 0", it, r.mode0Err); end
            busyRun(g);
            nTests++; if (g !== effGap(gp)) begin nFail++; $display("FAIL rand%0d_gap_busy got %0d want %0d", it, g, effGap(gp)); end
        end
    endtask

    task automatic test_continuous;
        msg_t r; bit ok; int n, g, w; logic [31:0] mw, sw;
        n  = $urandom_range(1, 8);
        mw = $urandom;
        sw = $urandom;
        busWrite(20'h84, 32'd2);
        busWrite(20'h88, n);
        busWrite(20'h8C, mw);
        busWrite(20'h90, sw);
        busWrite(20'h94, 32'd0);
        busWrite(20'h80, 32'd1);
        for (int k = 0; k < 3; k++) begin
            waitMsg(r, ok);
            nTests++; if (!ok) begin nFail++; $display("FAIL cont%0d_timeout got none want message", k); end
            nTests++; if (r.mosiBits !== expBits(mw, n) || r.misoBits !== expBits(sw, n)) begin nFail++; $display("FAIL cont%0d_bits got %h/%h want %h/%h", k, r.mosiBits, r.misoBits, expBits(mw, n), expBits(sw, n)); end
            nTests++; if (r.csLow !== expCsLow(2, n)) begin nFail++; $display("FAIL cont%0d_csLow got %0d want %0d", k, r.csLow, expCsLow(2, n)); end
            if (k > 0) begin
                nTests++; if (r.gapBefore !== 4) begin nFail++; $display("FAIL cont%0d_gap got %0d want 4", k, r.gapBefore); end
            end
        end
        w = 0;
        while (cs === 1'b1 && w < 100) begin
            @(negedge clk); #1;
            w++;
        end
        busWrite(20'h80, 32'd0);
        waitMsg(r, ok);
        nTests++; if (!ok) begin nFail++; $display("FAIL cont_last_timeout got none want message"); end
        nTests++; if (r.gapBefore !== 4) begin nFail++; $display("FAIL cont_last_gap got %0d want 4", r.gapBefore); end
        nTests++; if (r.mosiBits !== expBits(mw, n)) begin nFail++; $display("FAIL cont_last_mosi got %h want %h", r.mosiBits, expBits(mw, n)); end
        busyRun(g);
        nTests++; if (g !== 4) begin nFail++; $display("FAIL cont_stop_busy got %0d want 4", g); end
        idleCycles(60);
        nTests++; if (recs.size() !== 0 || cs !== 1'b1 || busy !== 1'b0) begin nFail++; $display("FAIL cont_idle got msgs=%0d cs=%b busy=%b want 0/1/0", recs.size(), cs, busy); end
    endtask

    task automatic test_midwrite;
        msg_t r; bit ok; int g, f0; logic [31:0] wa, wb;
        wa = $urandom;
        wb = ~wa;
        busWrite(20'h84, 32'd2);
        busWrite(20'h88, 32'd8);
        busWrite(20'h8C, wa);
        busWrite(20'h94, 32'd4);
        busWrite(20'h80, 32'd2);
        busWrite(20'h8C, wb);
        busWrite(20'h84, 32'd3);
        busWrite(20'h80, 32'd2);
        waitMsg(r, ok);
        nTests++; if (!ok) begin nFail++; $display("FAIL mid_timeout got none want message"); end
        nTests++; if (r.mosiBits !== expBits(wa, 8)) begin nFail++; $display("FAIL mid_old_word got %h want %h", r.mosiBits, expBits(wa, 8)); end
        nTests++; if (r.csLow !== 36) begin nFail++; $display("FAIL mid_old_half got %0d want 36", r.csLow); end
        busyRun(g);
        f0 = csFalls;
        idleCycles(50);
        nTests++; if (csFalls !== f0 || recs.size() !== 0) begin nFail++; $display("FAIL mid_start_ignored got falls=%0d msgs=%0d want %0d/0", csFalls, recs.size(), f0); end
        busWrite(20'h80, 32'd2);
        waitMsg(r, ok);
        nTests++; if (!ok) begin nFail++; $display("FAIL mid_next_timeout got none want message"); end
        nTests++; if (r.mosiBits !== expBits(wb, 8)) begin nFail++; $display("FAIL mid_new_word got %h want %h", r.mosiBits, expBits(wb, 8)); end
        nTests++; if (r.csLow !== 54) begin nFail++; $display("FAIL mid_new_half got %0d want 54", r.csLow); end
        busyRun(g);
    endtask

    task automatic test_async_reset;
        msg_t r; bit ok; int w, f0;
        busWrite(20'h84, 32'd4);
        busWrite(20'h88, 32'd12);
        busWrite(20'h8C, $urandom);
        busWrite(20'h80, 32'd2);
        w = 0;
        while (sclk !== 1'b1 && w < 200) begin
            @(negedge clk); #1;
            w++;
        end
        nTests++; if (sclk !== 1'b1) begin nFail++; $display("FAIL areset_reach_high got %b want 1", sclk); end
        #2 rstn = 1'b0;
        #1;
        nTests++; if (cs !== 1'b1 || sclk !== 1'b0) begin nFail++; $display("FAIL areset_immediate got cs=%b sclk=%b want 1/0", cs, sclk); end
        nTests++; if (busy !== 1'b0 || mosi !== 1'b0) begin nFail++; $display("FAIL areset_busy_mosi got %b/%b want 0/0", busy, mosi); end
        @(negedge clk); #1;
        rstn = 1'b1;
        idleCycles(3);
        recs.delete();
        f0 = csFalls;
        idleCycles(60);
        nTests++; if (csFalls !== f0 || cs !== 1'b1) begin nFail++; $display("FAIL areset_quiet got falls=%0d cs=%b want %0d/1", csFalls, cs, f0); end
        busWrite(20'h80, 32'd2);
        waitMsg(r, ok);
        nTests++; if (!ok) begin nFail++; $display("FAIL areset_restart_timeout got none want message"); end
        nTests++; if (r.csLow !== 170 || r.mosiBits !== expBits(32'h33AA, 16)) begin nFail++; $display("FAIL areset_defaults got csLow=%0d mosi=%h want 170/33aa", r.csLow, r.mosiBits); end
    endtask

    initial begin
        bus.sys_addr  = '0;
        bus.sys_wdata = '0;
        bus.sys_wen   = 1'b0;
        test_reset();
        test_default();
        test_clamp();
        test_n32();
        test_random();
        test_continuous();
        test_midwrite();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
